// File: rtl/pause_pkg.sv
// Shared types and helpers for the pause / dim controller.
//   dim_level_t : dim depth applied to the video stream
//   state_t     : controller state (RUN, WAIT, DIM)
//   ms_prescale : clk_sys cycles per millisecond for a given MHz clock
//   dim_chan    : per-channel attenuation, never overflows
package pause_pkg;

  typedef enum logic [1:0] {
    LVL_FULL = 2'd0,
    LVL_75   = 2'd1,
    LVL_50   = 2'd2,
    LVL_25   = 2'd3
  } dim_level_t;

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    WAIT = 2'd1,
    DIM  = 2'd2
  } state_t;

  localparam int unsigned FADE_STEP_MS = 250;
  // Wide enough for 63 s worth of milliseconds.
  localparam int unsigned MS_W         = 16;
  // Channels are processed zero-extended to this width.
  localparam int unsigned CHAN_W       = 16;

  function automatic int unsigned ms_prescale(int unsigned clkspeed);
    return clkspeed * 1000;
  endfunction

  function automatic logic [CHAN_W-1:0] dim_chan(logic [CHAN_W-1:0] x, dim_level_t lvl);
    logic [CHAN_W-1:0] r;
    case (lvl)
      LVL_FULL: r = x;
      LVL_75:   r = x - (x >> 2);
      LVL_50:   r = x >> 1;
      LVL_25:   r = x >> 2;
      default:  r = x;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/pause_ctrl_multi_if.sv
// Core-side signal bundle of pause_ctrl_multi.
//   master : the core / video side driving requests and pixels
//   slave  : the controller, returning dimmed pixels, pause_cpu and dimmed
interface pause_ctrl_multi_if #(
  parameter int unsigned RW      = 3,
  parameter int unsigned GW      = 3,
  parameter int unsigned BW      = 2,
  parameter int unsigned NUM_REQ = 2
);
  localparam int unsigned PixW = RW + GW + BW;

  logic               user_button;
  logic [NUM_REQ-1:0] pause_request;
  logic               OSD_STATUS;
  logic [1:0]         options;
  logic               dim_depth;
  logic [PixW-1:0]    rgb_in;
  logic [PixW-1:0]    rgb_out;
  logic               pause_cpu;
  logic               dimmed;

  modport master (
    output user_button, pause_request, OSD_STATUS, options, dim_depth, rgb_in,
    input  rgb_out, pause_cpu, dimmed
  );

  modport slave (
    input  user_button, pause_request, OSD_STATUS, options, dim_depth, rgb_in,
    output rgb_out, pause_cpu, dimmed
  );
endinterface

// File: rtl/pause_ms_timer.sv
// Millisecond prescaler plus saturating millisecond counter.
//   clk_sys, reset : clock, synchronous active-high reset
//   clr_i          : zero prescaler and ms counter (wins over en_i)
//   en_i           : advance the prescaler
//   tick_o         : prescaler wraps this cycle (one ms elapses)
//   ms_o           : completed milliseconds since last clear
module pause_ms_timer
  import pause_pkg::*;
#(
  parameter int unsigned MS_CYCLES = 12000
) (
  input  logic            clk_sys,
  input  logic            reset,
  input  logic            clr_i,
  input  logic            en_i,
  output logic            tick_o,
  output logic [MS_W-1:0] ms_o
);
  localparam int unsigned PW = (MS_CYCLES > 1) ? $clog2(MS_CYCLES) : 1;

  logic [PW-1:0]   presc_q, presc_d;
  logic [MS_W-1:0] ms_q, ms_d;

  assign tick_o = en_i && (presc_q == PW'(MS_CYCLES - 1));
  assign ms_o   = ms_q;

  always_comb begin
    presc_d = presc_q;
    ms_d    = ms_q;
    if (clr_i) begin
      presc_d = '0;
      ms_d    = '0;
    end else if (en_i) begin
      if (tick_o) begin
        presc_d = '0;
        if (ms_q != '1) ms_d = ms_q + 1'b1;
      end else begin
        presc_d = presc_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      presc_q <= '0;
      ms_q    <= '0;
    end else begin
      presc_q <= presc_d;
      ms_q    <= ms_d;
    end
  end
endmodule

// File: rtl/pause_ctrl_multi.sv
// CPU pause and video dim controller shared by arcade cores.
//   clk_sys, reset : clock, synchronous active-high reset
//   bus (slave)    : user_button, pause_request, OSD_STATUS, options, dim_depth, rgb_in in;
//                    rgb_out (registered), pause_cpu (registered), dimmed out
// MS_CYCLES overrides the CLKSPEED-derived ms prescale when non-zero.
// Build option PAUSE_FADE_EN: step the dim level 1 -> target, one step per 250 ms.
module pause_ctrl_multi
  import pause_pkg::*;
#(
  parameter int unsigned RW          = 3,
  parameter int unsigned GW          = 3,
  parameter int unsigned BW          = 2,
  parameter int unsigned CLKSPEED    = 12,
  parameter int unsigned NUM_REQ     = 2,
  parameter int unsigned DIM_SECONDS = 10,
  parameter int unsigned MS_CYCLES   = 0
) (
  input logic               clk_sys,
  input logic               reset,
  pause_ctrl_multi_if.slave bus
);
  localparam int unsigned MsCyc = (MS_CYCLES != 0) ? MS_CYCLES : ms_prescale(CLKSPEED);
  localparam int unsigned DimMs = DIM_SECONDS * 1000;
  localparam int unsigned PixW  = RW + GW + BW;

  state_t          state_q, state_d;
  dim_level_t      level_q, level_d;
  logic            user_paused_q, user_paused_d;
  logic            btn_prev_q, btn_prev_d;
  logic            pause_cpu_q, pause_cpu_d;
  logic [PixW-1:0] rgb_q, rgb_d;

  logic            soft_pause, dim_active;
  dim_level_t      target;
  logic            tmr_clr, tmr_en, tmr_tick;
  logic [MS_W-1:0] tmr_ms;

  pause_ms_timer #(
    .MS_CYCLES(MsCyc)
  ) u_timer (
    .clk_sys(clk_sys),
    .reset  (reset),
    .clr_i  (tmr_clr),
    .en_i   (tmr_en),
    .tick_o (tmr_tick),
    .ms_o   (tmr_ms)
  );

  always_comb begin
    soft_pause    = user_paused_q | (bus.options[0] & bus.OSD_STATUS);
    // System requests halt the CPU but never start the dim timer.
    dim_active    = soft_pause & bus.options[1];
    target        = bus.dim_depth ? LVL_25 : LVL_50;
    btn_prev_d    = bus.user_button;
    user_paused_d = user_paused_q ^ (bus.user_button & ~btn_prev_q);
    pause_cpu_d   = soft_pause | (|bus.pause_request);

    state_d = state_q;
    level_d = level_q;
    tmr_clr = 1'b0;
    tmr_en  = 1'b0;

    if (!dim_active) begin
      state_d = RUN;
      level_d = LVL_FULL;
      tmr_clr = 1'b1;
    end else begin
      case (state_q)
        RUN: begin
          state_d = WAIT;
          tmr_clr = 1'b1;
        end
        WAIT: begin
          tmr_en = 1'b1;
          if (tmr_tick && (tmr_ms == MS_W'(DimMs - 1))) begin
            state_d = DIM;
            tmr_clr = 1'b1;
`ifdef PAUSE_FADE_EN
            level_d = LVL_75;
`else
            level_d = target;
`endif
          end
        end
        DIM: begin
`ifdef PAUSE_FADE_EN
          tmr_en = 1'b1;
          if (level_q > target) begin
            level_d = target;
          end else if ((level_q != target) && tmr_tick &&
                       (tmr_ms == MS_W'(FADE_STEP_MS - 1))) begin
            level_d = dim_level_t'(level_q + 2'd1);
            tmr_clr = 1'b1;
          end
`else
          level_d = target;
`endif
        end
        default: begin
          state_d = RUN;
          level_d = LVL_FULL;
          tmr_clr = 1'b1;
        end
      endcase
    end

    rgb_d = {RW'(dim_chan(CHAN_W'(bus.rgb_in[PixW-1 -: RW]), level_q)),
             GW'(dim_chan(CHAN_W'(bus.rgb_in[GW+BW-1 -: GW]), level_q)),
             BW'(dim_chan(CHAN_W'(bus.rgb_in[BW-1:0]), level_q))};
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q       <= RUN;
      level_q       <= LVL_FULL;
      user_paused_q <= 1'b0;
      // Held at 1 so a button held through reset does not toggle.
      btn_prev_q    <= 1'b1;
      pause_cpu_q   <= 1'b0;
      rgb_q         <= '0;
    end else begin
      state_q       <= state_d;
      level_q       <= level_d;
      user_paused_q <= user_paused_d;
      btn_prev_q    <= btn_prev_d;
      pause_cpu_q   <= pause_cpu_d;
      rgb_q         <= rgb_d;
    end
  end

  assign bus.rgb_out   = rgb_q;
  assign bus.pause_cpu = pause_cpu_q;
  assign bus.dimmed    = (level_q != LVL_FULL);
endmodule
